// File: rtl/data_memory_pkg.sv
// Shared encodings for the data memory unit: access sizes, FSM states, big-endian lane constants.
// The misalignment helper is used only when DATAMEMORY_MISALIGN_TRAP_EN is defined.
package data_memory_pkg;
  localparam int DMEM_DW     = 32;
  localparam int DMEM_LANES  = 4;
  localparam int DMEM_BYTE_W = 8;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Big-endian: byte offset 0 is the most significant lane, i.e. byte-enable bit 3.
  localparam logic [3:0] BE_LANE0  = 4'b1000;
  localparam logic [3:0] BE_HALF0  = 4'b1100;
  localparam logic [3:0] BE_HALF1  = 4'b0011;
  localparam logic [3:0] BE_WORD   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = off[0];
      default:   is_misaligned = |off;
    endcase
  endfunction
endpackage

// File: rtl/data_memory_unit_if.sv
// Request/response bundle between the control unit and the data memory unit.
interface data_memory_unit_if #(parameter int DATAWIDTH_BUS = 32);
  logic                     CC_DataMemory_Req_In;
  logic                     CC_DataMemory_Write_In;
  logic [1:0]               CC_DataMemory_Size_In;
  logic                     CC_DataMemory_Signed_In;
  logic [DATAWIDTH_BUS-1:0] CC_DataMemory_Address_Bus_In;
  logic [DATAWIDTH_BUS-1:0] CC_DataMemory_WriteData_Bus_In;
  logic                     CC_DataMemory_Ready_Out;
  logic                     CC_DataMemory_Valid_Out;
  logic [DATAWIDTH_BUS-1:0] CC_DataMemory_Data_Bus_Out;
  logic                     CC_DataMemory_Selector_Out;
  logic                     CC_DataMemory_Error_Out;

  modport master (
    output CC_DataMemory_Req_In, CC_DataMemory_Write_In, CC_DataMemory_Size_In,
           CC_DataMemory_Signed_In, CC_DataMemory_Address_Bus_In, CC_DataMemory_WriteData_Bus_In,
    input  CC_DataMemory_Ready_Out, CC_DataMemory_Valid_Out, CC_DataMemory_Data_Bus_Out,
           CC_DataMemory_Selector_Out, CC_DataMemory_Error_Out
  );

  modport slave (
    input  CC_DataMemory_Req_In, CC_DataMemory_Write_In, CC_DataMemory_Size_In,
           CC_DataMemory_Signed_In, CC_DataMemory_Address_Bus_In, CC_DataMemory_WriteData_Bus_In,
    output CC_DataMemory_Ready_Out, CC_DataMemory_Valid_Out, CC_DataMemory_Data_Bus_Out,
           CC_DataMemory_Selector_Out, CC_DataMemory_Error_Out
  );
endinterface

// File: rtl/data_memory_lane_align.sv
// Combinational lane steering: store byte-enables and read-modify-write merge, load extraction
// with sign/zero extension. Low offset bits of misaligned halfword/word accesses are dropped.
module data_memory_lane_align
  import data_memory_pkg::*;
(
  input  logic [1:0]         size_i,
  input  logic [1:0]         offset_i,
  input  logic               signed_i,
  input  logic [DMEM_DW-1:0] wdata_i,
  input  logic [DMEM_DW-1:0] rword_i,
  output logic [3:0]         be_o,
  output logic [DMEM_DW-1:0] wword_o,
  output logic [DMEM_DW-1:0] rdata_o
);
  logic [1:0]         off;
  logic [DMEM_DW-1:0] sdata;
  logic [DMEM_DW-1:0] rshift;

  always_comb begin
    off   = offset_i;
    be_o  = BE_WORD;
    sdata = wdata_i;
    case (size_i)
      SIZE_BYTE: begin
        be_o  = BE_LANE0 >> off;
        sdata = {DMEM_LANES{wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        off[0] = 1'b0;
        be_o   = off[1] ? BE_HALF1 : BE_HALF0;
        sdata  = {2{wdata_i[15:0]}};
      end
      default: off = 2'b00;
    endcase

    for (int i = 0; i < DMEM_LANES; i++)
      wword_o[i*DMEM_BYTE_W +: DMEM_BYTE_W] = be_o[i] ? sdata[i*DMEM_BYTE_W +: DMEM_BYTE_W]
                                                      : rword_i[i*DMEM_BYTE_W +: DMEM_BYTE_W];

    // Shifting left by the offset brings the addressed lane to the top of the word.
    rshift = rword_i << {off, 3'b000};
    case (size_i)
      SIZE_BYTE: rdata_o = {{24{signed_i & rshift[31]}}, rshift[31:24]};
      SIZE_HALF: rdata_o = {{16{signed_i & rshift[31]}}, rshift[31:16]};
      default:   rdata_o = rword_i;
    endcase
  end
endmodule

// File: rtl/data_memory_unit.sv
// Load/store data memory: IDLE/ACCESS/RESP handshake FSM, request registers and local array.
// Define DATAMEMORY_MISALIGN_TRAP_EN to flag misaligned accesses instead of forcing alignment.
module data_memory_unit
  import data_memory_pkg::*;
#(
  parameter int DATAWIDTH_BUS = 32,
  parameter int ADDRWIDTH     = 10
) (
  input  logic              CC_DATAMEMORY_CLOCK_50,
  input  logic              CC_DATAMEMORY_RESET_InHigh,
  data_memory_unit_if.slave bus
);
  logic clk, rst;
  assign clk = CC_DATAMEMORY_CLOCK_50;
  assign rst = CC_DATAMEMORY_RESET_InHigh;

  dmem_state_e              state_q, state_d;
  logic                     write_q, signed_q;
  logic [1:0]               size_q;
  logic [ADDRWIDTH+1:0]     addr_q;
  logic [DATAWIDTH_BUS-1:0] wdata_q;
  logic [DATAWIDTH_BUS-1:0] data_q;
  logic [DATAWIDTH_BUS-1:0] mem_q [2**ADDRWIDTH];

  logic [ADDRWIDTH-1:0]     idx;
  logic [DATAWIDTH_BUS-1:0] rword, wword, rdata;
  logic [3:0]               be;
  logic                     err, mem_we, ld_upd, accept;

  assign idx    = addr_q[ADDRWIDTH+1:2];
  assign rword  = mem_q[idx];
  assign accept = (state_q == IDLE) && bus.CC_DataMemory_Req_In;

`ifdef DATAMEMORY_MISALIGN_TRAP_EN
  assign err = is_misaligned(size_q, addr_q[1:0]);
`else
  assign err = 1'b0;
`endif

  data_memory_lane_align u_align (
    .size_i   (size_q),
    .offset_i (addr_q[1:0]),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .rword_i  (rword),
    .be_o     (be),
    .wword_o  (wword),
    .rdata_o  (rdata)
  );

  always_comb begin
    state_d = state_q;
    mem_we  = 1'b0;
    ld_upd  = 1'b0;
    case (state_q)
      IDLE:   if (bus.CC_DataMemory_Req_In) state_d = ACCESS;
      ACCESS: begin
        state_d = RESP;
        mem_we  = write_q & ~err & (|be);
        ld_upd  = ~write_q & ~err;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= SIZE_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= bus.CC_DataMemory_Write_In;
        signed_q <= bus.CC_DataMemory_Signed_In;
        size_q   <= bus.CC_DataMemory_Size_In;
        addr_q   <= bus.CC_DataMemory_Address_Bus_In[ADDRWIDTH+1:0];
        wdata_q  <= bus.CC_DataMemory_WriteData_Bus_In;
      end
      if (ld_upd) data_q <= rdata;
    end
  end

  // Array is deliberately not reset; an async reset forces state_q out of ACCESS before the edge.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= wword;
  end

  assign bus.CC_DataMemory_Ready_Out    = (state_q == IDLE);
  assign bus.CC_DataMemory_Valid_Out    = (state_q == RESP);
  assign bus.CC_DataMemory_Selector_Out = (state_q == RESP) & ~write_q & ~err;
  assign bus.CC_DataMemory_Error_Out    = (state_q == RESP) & err;
  assign bus.CC_DataMemory_Data_Bus_Out = data_q;
endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit: directed requests push expectations, a negedge monitor checks.
module tb_data_memory_unit;
  import data_memory_pkg::*;

  localparam int AW = 10;

  typedef struct {
    logic [31:0] data;
    logic        sel;
    logic        err;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [31:0] last_ld = 32'h0;
  logic [31:0] exp10;

  data_memory_unit_if #(.DATAWIDTH_BUS(32)) dif ();

  data_memory_unit #(.DATAWIDTH_BUS(32), .ADDRWIDTH(AW)) dut (
    .CC_DATAMEMORY_CLOCK_50     (clk),
    .CC_DATAMEMORY_RESET_InHigh (rst),
    .bus                        (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every Valid pulse pops one expectation.
  always @(negedge clk) begin
    if (!rst && dif.CC_DataMemory_Valid_Out) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_data"}, dif.CC_DataMemory_Data_Bus_Out, e.data);
        chk({e.name, "_sel"},  {31'd0, dif.CC_DataMemory_Selector_Out}, {31'd0, e.sel});
        chk({e.name, "_err"},  {31'd0, dif.CC_DataMemory_Error_Out},    {31'd0, e.err});
      end
    end
  end

  task automatic drive(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    while (!dif.CC_DataMemory_Ready_Out && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
    dif.CC_DataMemory_Req_In           = 1'b1;
    dif.CC_DataMemory_Write_In         = wr;
    dif.CC_DataMemory_Size_In          = sz;
    dif.CC_DataMemory_Signed_In        = sg;
    dif.CC_DataMemory_Address_Bus_In   = addr;
    dif.CC_DataMemory_WriteData_Bus_In = wd;
  endtask

  // One request; err marks a trapped access. Also checks the 2-cycle latency.
  task automatic req(input string name, input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] ld_exp, input logic err);
    exp_t e;
    int   lat;
    drive(wr, sz, sg, addr, wd);
    if (!wr && !err) last_ld = ld_exp;
    e.data = last_ld; e.sel = !wr && !err; e.err = err; e.name = name;
    sb.push_back(e);
    @(posedge clk); #1;
    dif.CC_DataMemory_Req_In = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dif.CC_DataMemory_Valid_Out && lat < 10);
    chk({name, "_latency"}, lat, 2);
  endtask

  initial begin
    logic mis;
`ifdef DATAMEMORY_MISALIGN_TRAP_EN
    mis = 1'b1;
`else
    mis = 1'b0;
`endif
    dif.CC_DataMemory_Req_In           = 1'b0;
    dif.CC_DataMemory_Write_In         = 1'b0;
    dif.CC_DataMemory_Size_In          = SIZE_WORD;
    dif.CC_DataMemory_Signed_In        = 1'b0;
    dif.CC_DataMemory_Address_Bus_In   = '0;
    dif.CC_DataMemory_WriteData_Bus_In = '0;

    #23 rst = 1'b1;
    #4;
    chk("rst_ready", {31'd0, dif.CC_DataMemory_Ready_Out},    32'd1);
    chk("rst_valid", {31'd0, dif.CC_DataMemory_Valid_Out},    32'd0);
    chk("rst_sel",   {31'd0, dif.CC_DataMemory_Selector_Out}, 32'd0);
    chk("rst_err",   {31'd0, dif.CC_DataMemory_Error_Out},    32'd0);
    chk("rst_data",  dif.CC_DataMemory_Data_Bus_Out,          32'h0);
    @(negedge clk); rst = 1'b0;

    req("st_w10",   1, SIZE_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    req("ld_w10",   0, SIZE_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    req("st_b13",   1, SIZE_BYTE, 0, 32'h13, 32'h00000080, 32'h0, 0);
    req("ld_sb13",  0, SIZE_BYTE, 1, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    req("ld_ub13",  0, SIZE_BYTE, 0, 32'h13, 32'h0, 32'h00000080, 0);
    req("ld_w10b",  0, SIZE_WORD, 0, 32'h10, 32'h0, 32'hDEADBE80, 0);
    req("ld_sh10",  0, SIZE_HALF, 1, 32'h10, 32'h0, 32'hFFFFDEAD, 0);
    req("ld_uh10",  0, SIZE_HALF, 0, 32'h10, 32'h0, 32'h0000DEAD, 0);
    req("ld_alias", 0, SIZE_HALF, 0, 32'h10 + (32'd4 << AW), 32'h0, 32'h0000DEAD, 0);
    req("ld_uh12",  0, SIZE_HALF, 0, 32'h12, 32'h0, 32'h0000BE80, 0);
    req("ld_w12",   0, SIZE_WORD, 0, 32'h12, 32'h0, 32'hDEADBE80, mis);
    req("st_w12",   1, SIZE_WORD, 0, 32'h12, 32'h12345678, 32'h0, mis);
    exp10 = mis ? 32'hDEADBE80 : 32'h12345678;
    req("ld_w10c",  0, SIZE_WORD, 0, 32'h10, 32'h0, exp10, 0);

    // Req held high for 10 edges: acceptances only at edges 0, 3, 6, 9.
    drive(0, SIZE_WORD, 0, 32'h10, 32'h0);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.data = exp10; e.sel = 1'b1; e.err = 1'b0; e.name = "held";
      sb.push_back(e);
    end
    last_ld = exp10;
    repeat (10) @(posedge clk);
    #1 dif.CC_DataMemory_Req_In = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_drain", sb.size(), 0);

    req("st_w20",   1, SIZE_WORD, 0, 32'h20, 32'h11223344, 32'h0, 0);
    // Store aborted by reset during ACCESS: no expectation pushed, so any Valid is flagged.
    drive(1, SIZE_WORD, 0, 32'h20, 32'hAAAAAAAA);
    @(posedge clk); #1;
    dif.CC_DataMemory_Req_In = 1'b0;
    rst = 1'b1;
    #2;
    chk("abort_ready", {31'd0, dif.CC_DataMemory_Ready_Out}, 32'd1);
    chk("abort_valid", {31'd0, dif.CC_DataMemory_Valid_Out}, 32'd0);
    chk("abort_data",  dif.CC_DataMemory_Data_Bus_Out,       32'h0);
    @(posedge clk); #1 rst = 1'b0;
    last_ld = 32'h0;
    repeat (3) @(negedge clk);
    req("ld_w20",   0, SIZE_WORD, 0, 32'h20, 32'h0, 32'h11223344, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
